// File: rtl/wb_stage.sv
// Write-back stage with an integrated load unit.
//
// Accepts one instruction from MEM, optionally issues a single aligned doubleword read to data
// memory, extracts and extends the addressed byte/half/word/double, and writes the register file.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   valid_i_wb        - MEM offers an instruction
//   ready_o_wb        - stage can accept this cycle
//   rd_i_wb           - destination register
//   rd_we_i_wb        - instruction writes rd
//   result_i_wb       - ALU result, or byte address for loads
//   is_load_i_wb      - instruction is a load
//   load_op_i_wb      - load funct3 (lb/lh/lw/ld/lbu/lhu/lwu)
//   dmem_req_o_wb     - one-cycle data-memory read request
//   dmem_addr_o_wb    - doubleword-aligned request address
//   dmem_rvalid_i_wb  - read data valid
//   dmem_rdata_i_wb   - aligned 64-bit read data
//   we_o_wb           - register-file write enable
//   waddr_o_wb        - register-file write address
//   wdata_o_wb        - register-file write data
//   retire_o_wb       - one-cycle pulse per completed instruction
//   misalign_o_wb     - one-cycle pulse with retire on a misaligned load
module wb_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i_wb,
    output logic              ready_o_wb,
    input  logic [REG_AW-1:0] rd_i_wb,
    input  logic              rd_we_i_wb,
    input  logic [XLEN-1:0]   result_i_wb,
    input  logic              is_load_i_wb,
    input  logic [2:0]        load_op_i_wb,
    output logic              dmem_req_o_wb,
    output logic [XLEN-1:0]   dmem_addr_o_wb,
    input  logic              dmem_rvalid_i_wb,
    input  logic [XLEN-1:0]   dmem_rdata_i_wb,
    output logic              we_o_wb,
    output logic [REG_AW-1:0] waddr_o_wb,
    output logic [XLEN-1:0]   wdata_o_wb,
    output logic              retire_o_wb,
    output logic              misalign_o_wb
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StWrite
    } state_e;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q;
    logic              rd_we_q;
    logic [XLEN-1:0]   result_q;
    logic              is_load_q;
    logic [2:0]        load_op_q;
    logic [XLEN-1:0]   rdata_q;

    logic              accept;
    logic              capture;
    logic              mis_addr;
    logic              misaligned;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;

    // Alignment requirement follows the access size encoded in funct3[1:0].
    always_comb begin
        mis_addr = 1'b0;
        case (load_op_q[1:0])
            2'b00:   mis_addr = 1'b0;
            2'b01:   mis_addr = result_q[0];
            2'b10:   mis_addr = |result_q[1:0];
            default: mis_addr = |result_q[2:0];
        endcase
        misaligned = is_load_q & mis_addr;
    end

    // Move the addressed byte k down to bit 0; aligned accesses never run past byte 7.
    assign shifted = rdata_q >> {result_q[2:0], 3'b000};

    always_comb begin
        load_data = shifted;
        case (load_op_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            // ld, and the unused encoding 111 treated as ld.
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ready_o_wb     = 1'b0;
        dmem_req_o_wb  = 1'b0;
        dmem_addr_o_wb = '0;
        we_o_wb        = 1'b0;
        waddr_o_wb     = '0;
        wdata_o_wb     = '0;
        retire_o_wb    = 1'b0;
        misalign_o_wb  = 1'b0;
        capture        = 1'b0;

        case (state_q)
            StIdle: begin
                ready_o_wb = 1'b1;
            end
            StReq: begin
                if (misaligned) begin
                    state_d = StWrite;
                end else begin
                    dmem_req_o_wb  = 1'b1;
                    dmem_addr_o_wb = {result_q[XLEN-1:3], 3'b000};
                    state_d        = StWait;
                end
            end
            StWait: begin
                if (dmem_rvalid_i_wb) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                ready_o_wb    = 1'b1;
                retire_o_wb   = 1'b1;
                waddr_o_wb    = rd_q;
                wdata_o_wb    = is_load_q ? load_data : result_q;
                we_o_wb       = rd_we_q & (rd_q != '0) & ~misaligned;
                misalign_o_wb = misaligned;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        accept = valid_i_wb & ready_o_wb;
        if (accept) begin
            state_d = is_load_i_wb ? StReq : StWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            result_q  <= '0;
            is_load_q <= 1'b0;
            load_op_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q      <= rd_i_wb;
                rd_we_q   <= rd_we_i_wb;
                result_q  <= result_i_wb;
                is_load_q <= is_load_i_wb;
                load_op_q <= load_op_i_wb;
            end
            if (capture) begin
                rdata_q <= dmem_rdata_i_wb;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage with a transaction-level expectation model.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic [63:0] result_i;
    logic        is_load_i;
    logic [2:0]  load_op_i;
    logic        req_o;
    logic [63:0] addr_o;
    logic        rvalid_i;
    logic [63:0] rdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        retire_o;
    logic        mis_o;

    wb_stage #(
        .XLEN  (64),
        .REG_AW(5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i_wb      (valid_i),
        .ready_o_wb      (ready_o),
        .rd_i_wb         (rd_i),
        .rd_we_i_wb      (rd_we_i),
        .result_i_wb     (result_i),
        .is_load_i_wb    (is_load_i),
        .load_op_i_wb    (load_op_i),
        .dmem_req_o_wb   (req_o),
        .dmem_addr_o_wb  (addr_o),
        .dmem_rvalid_i_wb(rvalid_i),
        .dmem_rdata_i_wb (rdata_i),
        .we_o_wb         (we_o),
        .waddr_o_wb      (waddr_o),
        .wdata_o_wb      (wdata_o),
        .retire_o_wb     (retire_o),
        .misalign_o_wb   (mis_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic        mis;
        logic        chk_data;
    } wr_t;

    // Expectations keyed by cycle number.
    wr_t         exp_wr[int];
    logic [63:0] exp_req[int];
    bit          busy[int];
    bit          in_wait[int];
    logic [63:0] rv_plan[int];
    bit          post_rst[int];

    int cyc;
    int free_at;
    int n_checks;
    int n_err;
    bit chk_en;
    wr_t cw;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Loaded value from a doubleword, built byte by byte from the size and signedness.
    function automatic logic [63:0] model_load(input logic [2:0] op, input logic [63:0] addr,
                                               input logic [63:0] dw);
        int k = int'(addr[2:0]);
        int nb = 1 << op[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) begin
            if (k + i < 8) v[8*i +: 8] = dw[8*(k+i) +: 8];
        end
        if (!op[2] && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Default drive for a cycle: junk payload, planned or spurious rvalid, junk valid while busy.
    task automatic cycle_begin();
        valid_i   = 1'b0;
        rd_i      = 5'($urandom);
        rd_we_i   = 1'($urandom);
        result_i  = {$urandom, $urandom};
        is_load_i = 1'($urandom);
        load_op_i = 3'($urandom);
        rvalid_i  = 1'b0;
        rdata_i   = {$urandom, $urandom};
        if (rv_plan.exists(cyc)) begin
            rvalid_i = 1'b1;
            rdata_i  = rv_plan[cyc];
        end else if (!in_wait.exists(cyc) && $urandom_range(0, 3) == 0) begin
            rvalid_i = 1'b1;
        end
        if (cyc < free_at && $urandom_range(0, 1) == 1) valid_i = 1'b1;
    endtask

    // Offer an instruction this cycle (stage must be free) and schedule its effects.
    task automatic issue(input logic [4:0] rd, input logic we, input logic [63:0] res,
                         input logic ld, input logic [2:0] op, input int d,
                         input logic [63:0] dw, input logic lit_en, input logic [63:0] lit);
        wr_t w;
        int n = cyc;
        int sz = 1 << op[1:0];
        logic mis = ld && ((int'(res[2:0]) % sz) != 0);
        valid_i   = 1'b1;
        rd_i      = rd;
        rd_we_i   = we;
        result_i  = res;
        is_load_i = ld;
        load_op_i = op;
        w.waddr    = rd;
        w.mis      = mis;
        w.we       = we && (rd != 5'd0) && !mis;
        w.chk_data = !mis;
        w.wdata    = res;
        if (!ld) begin
            exp_wr[n+1] = w;
            free_at = n + 1;
        end else if (mis) begin
            busy[n+1] = 1'b1;
            exp_wr[n+2] = w;
            free_at = n + 2;
        end else begin
            exp_req[n+1] = {res[63:3], 3'b000};
            for (int c = n + 1; c <= n + 1 + d; c++) busy[c] = 1'b1;
            for (int c = n + 2; c <= n + d; c++) in_wait[c] = 1'b1;
            rv_plan[n+1+d] = dw;
            w.wdata = model_load(op, res, dw);
            exp_wr[n+2+d] = w;
            free_at = n + 2 + d;
        end
        if (lit_en) chk("model_pin", w.wdata, lit);
    endtask

    task automatic wait_free();
        while (cyc < free_at) begin
            cycle_begin();
            tick();
        end
    endtask

    task automatic purge_after(input int c);
        int ks[$];
        foreach (exp_wr[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_wr.delete(ks[i]);
        ks.delete();
        foreach (exp_req[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_req.delete(ks[i]);
        ks.delete();
        foreach (busy[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) busy.delete(ks[i]);
        ks.delete();
        foreach (in_wait[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) in_wait.delete(ks[i]);
        ks.delete();
        foreach (rv_plan[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) rv_plan.delete(ks[i]);
    endtask

    // Single compare process, sampling mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 64'(ready_o), busy.exists(cyc) ? 64'd0 : 64'd1);
            if (exp_req.exists(cyc)) begin
                chk("dmem_req", 64'(req_o), 64'd1);
                chk("dmem_addr", addr_o, exp_req[cyc]);
            end else begin
                chk("dmem_req", 64'(req_o), 64'd0);
            end
            if (exp_wr.exists(cyc)) begin
                cw = exp_wr[cyc];
                chk("retire", 64'(retire_o), 64'd1);
                chk("we", 64'(we_o), 64'(cw.we));
                chk("waddr", 64'(waddr_o), 64'(cw.waddr));
                chk("misalign", 64'(mis_o), 64'(cw.mis));
                if (cw.chk_data) chk("wdata", wdata_o, cw.wdata);
            end else begin
                chk("retire", 64'(retire_o), 64'd0);
                chk("we", 64'(we_o), 64'd0);
                chk("misalign", 64'(mis_o), 64'd0);
            end
            if (post_rst.exists(cyc)) begin
                chk("rst_waddr", 64'(waddr_o), 64'd0);
                chk("rst_wdata", wdata_o, 64'd0);
                chk("rst_addr", addr_o, 64'd0);
            end
        end
    end

    initial begin
        logic [4:0]  r_rd;
        logic [63:0] r_res;
        logic [2:0]  r_op;
        logic        r_ld;

        cyc = 0;
        n_checks = 0;
        n_err = 0;
        chk_en = 1'b0;
        free_at = 0;
        rst = 1'b1;
        valid_i = 1'b0;
        rd_i = '0;
        rd_we_i = 1'b0;
        result_i = '0;
        is_load_i = 1'b0;
        load_op_i = '0;
        rvalid_i = 1'b0;
        rdata_i = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        post_rst[cyc] = 1'b1;
        free_at = cyc;

        // ALU back-to-back.
        for (int i = 1; i <= 3; i++) begin
            cycle_begin();
            issue(5'(i), 1'b1, 64'h9 + 64'(i), 1'b0, 3'd0, 0, 64'd0, 1'b0, 64'd0);
            tick();
        end
        wait_free();

        // lb / lbu at 0x1003, rvalid two cycles after the request.
        cycle_begin();
        issue(5'd5, 1'b1, 64'h1003, 1'b1, 3'b000, 2, 64'h0000_0000_8000_0000,
              1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        wait_free();
        cycle_begin();
        issue(5'd6, 1'b1, 64'h1003, 1'b1, 3'b100, 2, 64'h0000_0000_8000_0000,
              1'b1, 64'h0000_0000_0000_0080);
        tick();
        wait_free();

        // lwu at 0x2004.
        cycle_begin();
        issue(5'd7, 1'b1, 64'h2004, 1'b1, 3'b110, 3, 64'hDEAD_BEEF_0000_0001,
              1'b1, 64'h0000_0000_DEAD_BEEF);
        tick();
        wait_free();

        // Misaligned lw at 0x3002.
        cycle_begin();
        issue(5'd8, 1'b1, 64'h3002, 1'b1, 3'b010, 1, 64'd0, 1'b0, 64'd0);
        tick();
        wait_free();

        // Write to x0 retires without a write.
        cycle_begin();
        issue(5'd0, 1'b1, 64'h1234, 1'b0, 3'd0, 0, 64'd0, 1'b0, 64'd0);
        tick();
        wait_free();

        // Reset during WAIT, then a late rvalid that must not write.
        cycle_begin();
        issue(5'd9, 1'b1, 64'h4000, 1'b1, 3'b011, 3, 64'h1111_2222_3333_4444, 1'b0, 64'd0);
        tick();
        cycle_begin();
        tick();
        purge_after(cyc);
        cycle_begin();
        rst = 1'b1;
        post_rst[cyc+1] = 1'b1;
        free_at = cyc + 1;
        tick();
        rst = 1'b0;
        cycle_begin();
        rvalid_i = 1'b1;
        rdata_i  = 64'h1111_2222_3333_4444;
        issue(5'd10, 1'b1, 64'h55, 1'b0, 3'd0, 0, 64'd0, 1'b0, 64'd0);
        tick();
        wait_free();

        // Randomized traffic.
        repeat (600) begin
            cycle_begin();
            if (cyc >= free_at && $urandom_range(0, 3) != 0) begin
                r_rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                r_ld  = 1'($urandom);
                r_op  = 3'($urandom_range(0, 6));
                r_res = {$urandom, $urandom};
                if (r_ld && $urandom_range(0, 1) == 1) begin
                    r_res[2:0] = r_res[2:0] & ~3'((1 << r_op[1:0]) - 1);
                end
                issue(r_rd, 1'($urandom), r_res, r_ld, r_op, $urandom_range(1, 4),
                      {$urandom, $urandom}, 1'b0, 64'd0);
            end
            tick();
        end
        while (cyc <= free_at + 2) begin
            cycle_begin();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters SHALL be: XLEN, 64, register/data width; REG_AW, 5, register address width.
REQ-002 Ports SHALL be:
  - clk  in  1  sole clock; all state updates on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - valid_i_wb  in  1  MEM stage offers an instruction.
  - ready_o_wb  out  1  stage can accept this cycle.
  - rd_i_wb  in  REG_AW  destination register.
  - rd_we_i_wb  in  1  instruction writes rd.
  - result_i_wb  in  XLEN  ALU result, or byte address for loads.
  - is_load_i_wb  in  1  instruction is a load.
  - load_op_i_wb  in  3  funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - dmem_req_o_wb  out  1  data-memory read request, one-cycle pulse.
  - dmem_addr_o_wb  out  XLEN  request address, 8-byte aligned.
  - dmem_rvalid_i_wb  in  1  read data valid.
  - dmem_rdata_i_wb  in  XLEN  aligned 64-bit doubleword.
  - we_o_wb  out  1  register-file write enable.
  - waddr_o_wb  out  REG_AW  register-file write address.
  - wdata_o_wb  out  XLEN  register-file write data.
  - retire_o_wb  out  1  one-cycle pulse per completed instruction.
  - misalign_o_wb  out  1  one-cycle pulse with retire on a misaligned load.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT, WRITE.
REQ-004 ready_o_wb SHALL be 1 in IDLE and WRITE, and 0 in REQ and WAIT.
REQ-005 Accept: on valid_i_wb & ready_o_wb, all inputs SHALL be latched; next state is REQ if is_load_i_wb, else WRITE.
REQ-006 REQ SHALL assert dmem_req_o_wb for exactly one cycle with dmem_addr_o_wb = addr & ~7, then go to WAIT.
  - A misaligned load (lh/lhu addr[0]≠0; lw/lwu addr[1:0]≠0; ld addr[2:0]≠0) SHALL skip the request and go directly to WRITE with the error flagged.
REQ-007 WAIT SHALL hold until dmem_rvalid_i_wb=1, capture dmem_rdata_i_wb, then go to WRITE; dmem_rvalid_i_wb SHALL be ignored in every other state.
REQ-008 Load extraction SHALL use byte offset k = addr[2:0].
  - lb/lbu: byte k; lh/lhu: halfword starting at byte k; lw/lwu: word starting at byte k; ld: the full doubleword.
  - Signed ops SHALL sign-extend to XLEN; u-variants SHALL zero-extend.
REQ-009 WRITE SHALL last exactly one cycle, with:
  - retire_o_wb=1;
  - waddr_o_wb=latched rd;
  - wdata_o_wb=latched result, or the extracted load data;
  - we_o_wb=rd_we & (rd≠0) & ~misaligned;
  - misalign_o_wb=1 only for a misaligned load.
REQ-010 In WRITE, a new accept SHALL follow REQ-005; with no accept, the next state is IDLE.
REQ-011 Outside WRITE, we_o_wb, retire_o_wb and misalign_o_wb SHALL be 0.
REQ-012 Latency: a non-load accepted at cycle N writes at N+1, giving sustained throughput of 1 per cycle. An aligned load accepted at N requests at N+1 and writes one cycle after rvalid (earliest N+3). A misaligned load writes at N+2.
REQ-013 Writes to x0 SHALL never assert we_o_wb but SHALL still retire.

Reset
REQ-014 While rst=1, the state SHALL become IDLE at the clock edge, and all outputs SHALL be 0 from the following cycle, except ready_o_wb=1.
REQ-015 Reset during REQ or WAIT SHALL abandon the load; a late dmem_rvalid_i_wb SHALL cause no write.

Verification
REQ-016 ALU back-to-back: valid=1 for 3 cycles, rd=1,2,3, results 0xA,0xB,0xC -> we=1 on 3 consecutive cycles, writing x1=0xA, x2=0xB, x3=0xC; ready stays 1.
REQ-017 Load lb at addr 0x1003, rdata 0x0000_0000_8000_0000, rvalid 2 cycles after req -> dmem_addr=0x1000; after rvalid, wdata=0xFFFF_FFFF_FFFF_FF80; same data with lbu -> wdata=0x80.
REQ-018 Load lwu at addr 0x2004, rdata 0xDEAD_BEEF_0000_0001 -> wdata=0x0000_0000_DEAD_BEEF; ready=0 from REQ until WRITE.
REQ-019 Misaligned lw at addr 0x3002 -> no dmem_req; 2 cycles after accept: retire=1, misalign=1, we=0.
REQ-020 ALU op rd=0, rd_we=1 -> retire=1, we=0.
REQ-021 rst pulsed during WAIT, then rvalid=1 -> no we and no retire; next accept proceeds normally.
